// File: rtl/fetch_if.sv
// fetch_if: hazard/execute-side controls and fetch-side outputs of the fetch stage.
interface fetch_if;
  logic        Stall_En;
  logic        Redirect_E;
  logic [31:0] Redirect_PC_E;
  logic        Update_En_E;
  logic [31:0] Update_PC_E;
  logic [31:0] Update_Target_E;
  logic        Update_Taken_E;
  logic [31:0] PC_F;
  logic [31:0] PC_Plus_4_F;
  logic        Predict_Taken_F;
  logic        Valid_F;
  modport master (
    output Stall_En, Redirect_E, Redirect_PC_E, Update_En_E, Update_PC_E, Update_Target_E, Update_Taken_E,
    input  PC_F, PC_Plus_4_F, Predict_Taken_F, Valid_F
  );
  modport slave (
    input  Stall_En, Redirect_E, Redirect_PC_E, Update_En_E, Update_PC_E, Update_Target_E, Update_Taken_E,
    output PC_F, PC_Plus_4_F, Predict_Taken_F, Valid_F
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32i fetch stage with PC register and direct-mapped BTB of 2-bit counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input logic   CLK,
  input logic   RST,
  fetch_if.slave bus
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = 30 - IDX;
  logic [31:0]            pc_q, pc_d;
  logic                   valid_q;
  logic [BTB_ENTRIES-1:0] v;
  logic [TW-1:0]          tag [BTB_ENTRIES];
  logic [29:0]            tgt [BTB_ENTRIES];
  logic [1:0]             ctr [BTB_ENTRIES];
  logic [IDX-1:0]         lidx, uidx;
  logic                   hit, pred, uhit, unused_bits;
  logic [1:0]             uc, uc_n;
  assign lidx = pc_q[IDX+1:2];
  assign uidx = bus.Update_PC_E[IDX+1:2];
  assign hit  = v[lidx] && tag[lidx] == pc_q[31:IDX+2];
  assign pred = hit && ctr[lidx][1] && valid_q;
  assign uhit = v[uidx] && tag[uidx] == bus.Update_PC_E[31:IDX+2];
  assign uc   = ctr[uidx];
  assign uc_n = bus.Update_Taken_E ? (uc == 2'b11 ? uc : uc + 2'b01)
                                   : (uc == 2'b00 ? uc : uc - 2'b01);
  assign unused_bits = ^{bus.Update_PC_E[1:0], bus.Update_Target_E[1:0]};
  // The first edge out of reset only raises valid; the reset PC itself is fetched next.
  always_comb
    pc_d = !valid_q        ? pc_q :
           bus.Redirect_E  ? bus.Redirect_PC_E :
           bus.Stall_En    ? pc_q :
           pred            ? {tgt[lidx], 2'b00} :
                             pc_q + 32'd4;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      v       <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      if (bus.Update_En_E && bus.Update_Taken_E) v[uidx] <= 1'b1;
    end
  always_ff @(posedge CLK)
    if (bus.Update_En_E) begin
      if (uhit) ctr[uidx] <= uc_n;
      else if (bus.Update_Taken_E) begin
        ctr[uidx] <= 2'b10;
        tag[uidx] <= bus.Update_PC_E[31:IDX+2];
      end
      if (bus.Update_Taken_E) tgt[uidx] <= bus.Update_Target_E[31:2];
    end
  assign bus.PC_F            = pc_q;
  assign bus.PC_Plus_4_F     = pc_q + 32'd4;
  assign bus.Predict_Taken_F = pred;
  assign bus.Valid_F         = valid_q;
endmodule
